timer_unit: RTL and testbench
=============================

Name: timer_unit

Overview:
- Memory-mapped 32-bit timer/compare block with a prescaler.
- Sits directly upstream of the interrupt controller and drives its irq_timer input with a one-cycle pulse on each compare match.
- The CPU programs it over the same a/d/we/spo bus style as the interrupt controller.
- The handler clears the sticky status bit through the same bus.

Parameters:
- BASE, 32'h80100000, base address; decoded on a[31:5]. Registers are at offsets a[4:2].
- PRESCALE_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset); one clock domain only
- a  input  32  bus address
- d  input  32  bus write data
- we  input  1  write strobe, qualified by the address decode below
- spo  output  32  combinational read data
- irq_timer  output  1  registered one-cycle pulse on a compare match; goes to the interrupt controller
- running  output  1  mirror of CTRL.en, for debug LED

Behaviour:
- Select: sel = (a[31:5] == BASE[31:5]). A write happens only when we & sel.
- Register map (byte offset):
  - 0x00 CTRL: bit0 en, bit1 autoreload, bit2 ie.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 COMPARE: 32 bits.
  - 0x0C COUNT: 32 bits, read/write.
  - 0x10 STATUS: bit0 pending, write-1-to-clear.
  - 0x14 to 0x1C read 0, and writes to them are ignored.
- Read: spo is combinational from a[4:2]. Unused bits read 0. spo does not depend on sel; the bus muxes it.
- Reset (rst=0, async): CTRL=0, PRESCALE=0, COMPARE=32'hFFFFFFFF, COUNT=0, pcnt=0, pending=0, irq_timer=0, running=0.
- Prescaler: when en=1, tick = (pcnt == PRESCALE).
  - On tick, pcnt <= 0; otherwise pcnt <= pcnt+1.
  - PRESCALE=0 gives a tick every cycle.
  - When en=0, pcnt holds and there is no tick.
- Counter, on tick:
  - If COUNT == COMPARE, a match occurs.
    - autoreload=1: COUNT <= 0, en stays 1.
    - autoreload=0 (one-shot): COUNT holds and en <= 0.
  - Otherwise COUNT <= COUNT+1. It wraps 32'hFFFFFFFF -> 0 silently, with no match unless COMPARE equals that value.
- Match effects:
  - pending <= 1.
  - irq_timer <= ie, as a single pulse in the cycle after the tick. Latency from the matching tick edge to irq_timer high is 1 clk.
  - irq_timer is never held for more than 1 cycle.
  - COMPARE=0 with autoreload gives a match on every tick (period = PRESCALE+1 clk).
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the written value wins, pcnt <= 0, and no match is evaluated that cycle.
  - A CTRL write in the same cycle as a one-shot match: the written value wins, so en follows d[0].
  - A STATUS clear in the same cycle as a match: the set wins, so pending stays 1.
  - A PRESCALE write does not reset pcnt. If pcnt > the new PRESCALE, pcnt counts up to 2^PRESCALE_W-1, wraps, then ticks normally.
  - A COMPARE write below the current COUNT: the counter runs to the wrap and then on to COMPARE.
- Writing en=1 from 0 does not clear COUNT or pcnt; software clears them explicitly.
- Reset asserted mid-count: all state clears immediately, asynchronously. No irq_timer pulse follows reset release.
- The interrupt controller latches irq_timer into its own save bit. pending is for software polling only.

Decomposition:
- Shared package timer_pkg:
  - Offset constants TMR_CTRL=3'd0, TMR_PRESCALE=3'd1, TMR_COMPARE=3'd2, TMR_COUNT=3'd3, TMR_STATUS=3'd4.
  - CTRL bit indices EN=0, AR=1, IE=2.
  - Default BASE.
- One sub-module: timer_prescaler (pcnt register plus tick generation, with inputs en, prescale, clr). The counter/compare and bus logic stay in timer_unit.

Test Plan:
- Reset check: hold rst=0 for 3 clk, release.
  - Required: spo at 0x08 = FFFFFFFF; spo at 0x00, 0x0C, 0x10 = 0; irq_timer=0 for 20 clk.
- Autoreload periodic: write PRESCALE=3, COMPARE=4, CTRL=7.
  - Required: irq_timer pulses exactly 1 clk wide, every 20 clk.
  - Required: COUNT reads cycle 0..4.
  - Required: STATUS reads 1 until a write of 1 to 0x10.
- One-shot: COMPARE=2, PRESCALE=0, CTRL=5.
  - Required: exactly one pulse, 3 ticks after enable (pulse in the following cycle).
  - Required: then CTRL reads 4, COUNT holds at 2, and there are no further pulses for 50 clk.
- Collisions:
  - Write COUNT=100 on the same cycle as a tick → COUNT reads 100, and the prescaler restarts from 0.
  - Write STATUS=1 on the same cycle as a match → STATUS reads 1.
- Wrap: COMPARE=5, COUNT=FFFFFFFE, PRESCALE=0, CTRL=3 (ie=0).
  - Required: COUNT goes FFFFFFFF, 0, …, 5, then match, pending=1, irq_timer stays 0.
- Async reset mid-run: assert rst=0 between clock edges during autoreload.
  - Required: COUNT and pending read 0 immediately, and irq_timer=0 combinationally after the flop clear.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the memory-mapped compare timer: register offsets,
// CTRL bit positions and the default bus base address.
package timer_pkg;

    localparam logic [31:0] TMR_BASE_DEFAULT = 32'h8010_0000;
    localparam int          TMR_PRESCALE_W   = 16;

    localparam logic [2:0] TMR_CTRL     = 3'd0;
    localparam logic [2:0] TMR_PRESCALE = 3'd1;
    localparam logic [2:0] TMR_COMPARE  = 3'd2;
    localparam logic [2:0] TMR_COUNT    = 3'd3;
    localparam logic [2:0] TMR_STATUS   = 3'd4;

    localparam int EN = 0;
    localparam int AR = 1;
    localparam int IE = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the compare timer: counts clocks while enabled and emits a
// tick whenever the count equals the programmed prescale value.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = TMR_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // A prescale value below the current count is reached only after the
    // counter wraps through its full range.
    always_comb begin
        tick   = en && (pcnt_q == prescale);
        pcnt_d = pcnt_q;
        if (clr) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped 32-bit compare timer with prescaler; pulses irq_timer for one
// cycle on every compare match and keeps a sticky, write-1-to-clear status bit.
module timer_unit
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE       = TMR_BASE_DEFAULT,
    parameter int          PRESCALE_W = TMR_PRESCALE_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        irq_timer,
    output logic        running
);

    logic [2:0]            ctrl_q,     ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           compare_q,  compare_d;
    logic [31:0]           count_q,    count_d;
    logic                  pending_q,  pending_d;
    logic                  irq_q,      irq_d;

    logic       sel;
    logic       wr;
    logic [2:0] off;
    logic       wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
    logic       tick;
    logic       match;
    logic [1:0] unused_a;

    assign unused_a = a[1:0];

    assign sel         = (a[31:5] == BASE[31:5]);
    assign wr          = we && sel;
    assign off         = a[4:2];
    assign wr_ctrl     = wr && (off == TMR_CTRL);
    assign wr_prescale = wr && (off == TMR_PRESCALE);
    assign wr_compare  = wr && (off == TMR_COMPARE);
    assign wr_count    = wr && (off == TMR_COUNT);
    assign wr_status   = wr && (off == TMR_STATUS);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_q[EN]),
        .prescale (prescale_q),
        .clr      (wr_count),
        .tick     (tick)
    );

    // A software COUNT write overrides the tick, so no compare is evaluated.
    assign match = tick && !wr_count && (count_q == compare_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        pending_d  = pending_q;
        irq_d      = match && ctrl_q[IE];

        if (match && !ctrl_q[AR]) begin
            ctrl_d[EN] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = d[2:0];
        end

        if (wr_prescale) begin
            prescale_d = d[PRESCALE_W-1:0];
        end
        if (wr_compare) begin
            compare_d = d;
        end

        if (wr_count) begin
            count_d = d;
        end else if (match) begin
            count_d = ctrl_q[AR] ? 32'd0 : count_q;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end

        // Set has priority over a clear arriving in the same cycle.
        if (match) begin
            pending_d = 1'b1;
        end else if (wr_status && d[0]) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            count_q    <= '0;
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        spo = '0;
        case (off)
            TMR_CTRL:     spo[2:0]            = ctrl_q;
            TMR_PRESCALE: spo[PRESCALE_W-1:0] = prescale_q;
            TMR_COMPARE:  spo                 = compare_q;
            TMR_COUNT:    spo                 = count_q;
            TMR_STATUS:   spo[0]              = pending_q;
            default:      spo                 = '0;
        endcase
    end

    assign irq_timer = irq_q;
    assign running   = ctrl_q[EN];

endmodule

// File: tb/tb_timer_unit.sv
// Self-checking bench for timer_unit: register-map vector table, directed
// corner-case sequences and a randomized run against a software model.
module tb_timer_unit;

    localparam logic [31:0] BASE   = 32'h8010_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        irq_timer;
    logic        running;

    always #5 clk = ~clk;

    timer_unit #(
        .BASE       (BASE),
        .PRESCALE_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .d         (d),
        .we        (we),
        .spo       (spo),
        .irq_timer (irq_timer),
        .running   (running)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // irq pulse log: negedge index of every cycle with irq_timer high
    int cyc = 0;
    int pulse_t[$];
    always @(negedge clk) begin
        cyc++;
        if (irq_timer === 1'b1) pulse_t.push_back(cyc);
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        a  = addr;
        d  = data;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = spo;
    endtask

    task automatic do_reset();
        we  = 1'b0;
        a   = BASE;
        d   = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Reference model: the timer as software sees it
    bit          m_en, m_ar, m_ie, m_pend, m_irq;
    int unsigned m_pre, m_pcnt;
    logic [31:0] m_cmp, m_cnt;

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_irq = 0;
        m_pre = 0; m_pcnt = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] ad);
        case (ad[4:2])
            3'd0:    return {29'd0, m_ie, m_ar, m_en};
            3'd1:    return 32'(m_pre);
            3'd2:    return m_cmp;
            3'd3:    return m_cnt;
            3'd4:    return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] ad, input logic [31:0] dd, input logic w);
        bit          sel_hit = w && (ad[31:5] == BASE[31:5]);
        int          o       = int'(ad[4:2]);
        bit          wcnt    = sel_hit && (o == 3);
        bit          tick    = m_en && (m_pcnt == m_pre);
        bit          hit     = tick && !wcnt && (m_cnt == m_cmp);
        int unsigned n_pcnt  = m_pcnt;
        logic [31:0] n_cnt   = m_cnt;
        bit          n_en    = m_en;

        if (wcnt || tick)  n_pcnt = 0;
        else if (m_en)     n_pcnt = (m_pcnt + 1) % 65536;

        if (wcnt)          n_cnt = dd;
        else if (hit)      n_cnt = m_ar ? 32'd0 : m_cnt;
        else if (tick)     n_cnt = m_cnt + 32'd1;

        if (hit && !m_ar)  n_en = 0;

        m_irq = hit && m_ie;
        if (hit)                               m_pend = 1;
        else if (sel_hit && o == 4 && dd[0])   m_pend = 0;

        if (sel_hit && o == 0) begin
            n_en = dd[0]; m_ar = dd[1]; m_ie = dd[2];
        end
        if (sel_hit && o == 1) m_pre = int'(dd[15:0]);
        if (sel_hit && o == 2) m_cmp = dd;
        m_en   = n_en;
        m_cnt  = n_cnt;
        m_pcnt = n_pcnt;
    endtask

    typedef struct {
        logic [31:0] wa;
        logic [31:0] wd;
        logic        wr;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int p0;
        int n;
        int seen;
        bit got;

        vecs[0]  = '{A_PRE,  32'hABCD_1234, 1'b1, A_PRE,          32'h0000_1234};
        vecs[1]  = '{A_CMP,  32'h1234_5678, 1'b1, A_CMP,          32'h1234_5678};
        vecs[2]  = '{A_CNT,  32'hCAFE_F00D, 1'b1, A_CNT,          32'hCAFE_F00D};
        vecs[3]  = '{A_CTRL, 32'hFFFF_FFF6, 1'b1, A_CTRL,         32'h0000_0006};
        vecs[4]  = '{BASE + 32'h14, 32'hFFFF_FFFF, 1'b1, BASE + 32'h14, 32'h0};
        vecs[5]  = '{BASE + 32'h1C, 32'hFFFF_FFFF, 1'b1, BASE + 32'h18, 32'h0};
        vecs[6]  = '{A_CMP ^ 32'h0000_0100, 32'h0, 1'b1, A_CMP,   32'h1234_5678};
        vecs[7]  = '{A_CNT,  32'h0000_0005, 1'b0, A_CNT,          32'hCAFE_F00D};
        vecs[8]  = '{A_STAT, 32'h0000_0001, 1'b1, A_STAT,         32'h0};
        vecs[9]  = '{A_CTRL, 32'h0000_0000, 1'b0, A_PRE + 32'd3,  32'h0000_1234};
        vecs[10] = '{A_CTRL, 32'h0000_0000, 1'b1, A_CTRL,         32'h0};

        // ---- reset values
        do_reset();
        rd(A_CMP, v);  chk("reset_compare", v, 32'hFFFF_FFFF);
        rd(A_CTRL, v); chk("reset_ctrl", v, 32'h0);
        rd(A_CNT, v);  chk("reset_count", v, 32'h0);
        rd(A_STAT, v); chk("reset_status", v, 32'h0);
        chk("reset_running", 32'(running), 32'h0);
        p0 = pulse_t.size();
        repeat (20) @(negedge clk);
        #2;
        chk("reset_no_irq", 32'(pulse_t.size() - p0), 32'd0);

        // ---- register map table (timer stays disabled)
        foreach (vecs[i]) begin
            a  = vecs[i].wa;
            d  = vecs[i].wd;
            we = vecs[i].wr;
            @(negedge clk);
            we = 1'b0;
            rd(vecs[i].ra, v);
            chk($sformatf("regmap_vec%0d", i), v, vecs[i].exp);
        end
        chk("regmap_running", 32'(running), 32'h0);

        // ---- autoreload periodic
        do_reset();
        @(negedge clk);
        bus_write(A_PRE, 32'd3);
        bus_write(A_CMP, 32'd4);
        p0 = pulse_t.size();
        bus_write(A_CTRL, 32'd7);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            rd(A_CNT, v);
            chk("ar_count_range", 32'(v <= 32'd4), 32'd1);
            if (v <= 32'd4) seen |= (1 << v);
        end
        chk("ar_count_values", 32'(seen), 32'h1F);
        #2;
        n = pulse_t.size() - p0;
        chk("ar_pulse_count", 32'(n >= 4), 32'd1);
        for (int i = 1; i < n; i++)
            chk("ar_pulse_period", 32'(pulse_t[p0 + i] - pulse_t[p0 + i - 1]), 32'd20);
        rd(A_STAT, v); chk("ar_status_set", v, 32'd1);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            #1;
            if (irq_timer === 1'b1) got = 1;
        end
        chk("ar_wait_pulse", 32'(got), 32'd1);
        bus_write(A_STAT, 32'd1);
        rd(A_STAT, v); chk("ar_status_cleared", v, 32'd0);

        // ---- one-shot
        do_reset();
        @(negedge clk);
        bus_write(A_CMP, 32'd2);
        bus_write(A_PRE, 32'd0);
        p0 = pulse_t.size();
        bus_write(A_CTRL, 32'd5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("os_irq_cycle%0d", k), 32'(irq_timer), 32'(k == 3));
        end
        repeat (50) @(negedge clk);
        #2;
        chk("os_single_pulse", 32'(pulse_t.size() - p0), 32'd1);
        rd(A_CTRL, v); chk("os_ctrl", v, 32'd4);
        rd(A_CNT, v);  chk("os_count_hold", v, 32'd2);
        chk("os_running", 32'(running), 32'd0);

        // ---- COUNT write colliding with a tick, then a non-tick restart
        do_reset();
        @(negedge clk);
        bus_write(A_PRE, 32'd3);
        bus_write(A_CMP, 32'd1000);
        bus_write(A_CTRL, 32'd1);
        repeat (3) @(negedge clk);
        bus_write(A_CNT, 32'd100);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            rd(A_CNT, v);
            chk($sformatf("col_count_t%0d", k), v, (k == 4) ? 32'd101 : 32'd100);
        end
        bus_write(A_CNT, 32'd200);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            rd(A_CNT, v);
            chk($sformatf("col_restart_t%0d", k), v, (k == 4) ? 32'd201 : 32'd200);
        end

        // ---- STATUS clear colliding with a match (match every cycle, ie=0)
        do_reset();
        @(negedge clk);
        bus_write(A_CMP, 32'd0);
        bus_write(A_PRE, 32'd0);
        p0 = pulse_t.size();
        bus_write(A_CTRL, 32'd3);
        @(negedge clk);
        rd(A_STAT, v); chk("col_status_pre", v, 32'd1);
        bus_write(A_STAT, 32'd1);
        rd(A_STAT, v); chk("col_status_set_wins", v, 32'd1);
        #2;
        chk("col_no_irq_ie0", 32'(pulse_t.size() - p0), 32'd0);

        // ---- wrap through 0xFFFFFFFF
        do_reset();
        @(negedge clk);
        bus_write(A_CMP, 32'd5);
        bus_write(A_CNT, 32'hFFFF_FFFE);
        bus_write(A_PRE, 32'd0);
        p0 = pulse_t.size();
        bus_write(A_CTRL, 32'd3);
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] e;
            @(negedge clk);
            e = (k == 1) ? 32'hFFFF_FFFF : (k == 8) ? 32'd0 : 32'(k - 2);
            rd(A_CNT, v);  chk($sformatf("wrap_count_t%0d", k), v, e);
            rd(A_STAT, v); chk($sformatf("wrap_pending_t%0d", k), v, 32'(k == 8));
        end
        #2;
        chk("wrap_no_irq", 32'(pulse_t.size() - p0), 32'd0);

        // ---- async reset mid-run
        do_reset();
        @(negedge clk);
        bus_write(A_PRE, 32'd0);
        bus_write(A_CMP, 32'd3);
        bus_write(A_CTRL, 32'd7);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (irq_timer === 1'b1) got = 1;
        end
        chk("arst_pulse_seen", 32'(got), 32'd1);
        rd(A_STAT, v); chk("arst_pending_before", v, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_irq", 32'(irq_timer), 32'd0);
        chk("arst_running", 32'(running), 32'd0);
        rd(A_CNT, v);  chk("arst_count", v, 32'd0);
        rd(A_STAT, v); chk("arst_pending", v, 32'd0);
        rd(A_CMP, v);  chk("arst_compare", v, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        p0 = pulse_t.size();
        repeat (10) @(negedge clk);
        #2;
        chk("arst_no_irq_after", 32'(pulse_t.size() - p0), 32'd0);

        // ---- randomized run against the model
        do_reset();
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            int          r;
            int          o;
            logic [31:0] ad, dd;
            @(negedge clk);
            r  = $urandom_range(0, 99);
            o  = $urandom_range(0, 7);
            ad = BASE + 32'(o * 4) + 32'($urandom_range(0, 3));
            if (r < 5) ad = ad ^ 32'h0001_0000;
            case (o)
                0: dd = $urandom | ((r % 3 != 0) ? 32'd1 : 32'd0);
                1: dd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 3));
                2: dd = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                    : 32'($urandom_range(0, 6));
                3: dd = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                    : 32'($urandom_range(0, 6));
                default: dd = $urandom;
            endcase
            a  = ad;
            d  = dd;
            we = (r < 20);
            #1;
            chk("rnd_spo", spo, model_read(ad));
            chk("rnd_irq", 32'(irq_timer), 32'(m_irq));
            chk("rnd_running", 32'(running), 32'(m_en));
            @(posedge clk);
            model_step(ad, dd, (r < 20));
        end
        @(negedge clk);
        we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
